// File: rtl/pipeline_reg_pkg.sv
// Shared types and constants for the pipeline_reg valid/ready register slice.
// The state encoding is shared by the top and by any bench that wants to name states.
package pipeline_reg_pkg;

  localparam int unsigned DefaultWidth = 32;

  // EMPTY: nothing held; BUSY: main entry holds a beat; FULL: main and skid both hold beats.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic logic state_out_valid(state_e st);
    return st != StEmpty;
  endfunction

  function automatic logic state_in_ready(state_e st);
    return st != StFull;
  endfunction

endpackage

// File: rtl/pipeline_reg_entry.sv
// One payload entry of the slice: a load-enabled register with synchronous clear.
// Instantiated twice by pipeline_reg (main entry driving rdata, and the skid entry).
module pipeline_reg_entry #(
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/pipeline_reg.sv
// Full-throughput valid/ready register slice: forward valid/data and backward ready are all
// registered, a skid entry absorbs the one beat that arrives while the consumer stalls.
module pipeline_reg
  import pipeline_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rdata
);

  state_e r_state;
  state_e w_state_d;
  logic   r_out_valid;
  logic   r_in_ready;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_din;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // Handshakes use only the registered flags, so no input reaches an output combinationally.
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: begin
        if (w_in_xfer) w_state_d = StBusy;
      end
      StBusy: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_d = StFull;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_out_xfer) w_state_d = StBusy;
      end
      default: w_state_d = StEmpty;
    endcase
  end

  // Main reloads on any accepted beat that goes straight through, or from skid when draining.
  always_comb begin
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_din  = wdata;
    unique case (r_state)
      StEmpty: begin
        w_main_load = w_in_xfer;
      end
      StBusy: begin
        w_main_load = w_in_xfer & w_out_xfer;
        w_skid_load = w_in_xfer & ~w_out_xfer;
      end
      StFull: begin
        w_main_load = w_out_xfer;
        w_main_din  = w_skid_q;
      end
      default: begin
        w_main_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= state_out_valid(w_state_d);
      r_in_ready  <= state_in_ready(w_state_d);
    end
  end

  pipeline_reg_entry #(
    .Width (WIDTH)
  ) u_main (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_main_load),
    .i_data (w_main_din),
    .o_data (w_main_q)
  );

  pipeline_reg_entry #(
    .Width (WIDTH)
  ) u_skid (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_skid_load),
    .i_data (wdata),
    .o_data (w_skid_q)
  );

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign rdata     = w_main_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// Scoreboard bench for pipeline_reg: accepted beats are queued as expectations and a monitor
// compares each beat the slice emits, alongside directed checks of ready/valid/stability.
module tb_pipeline_reg;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] wdata;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rdata;

  logic [W-1:0] sb_q[$];
  int           n_checks;
  int           n_fail;

  pipeline_reg #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wdata     (wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding accepted beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none at %0t", rdata, $time);
      end else begin
        check("scoreboard_rdata", rdata, sb_q.pop_front());
      end
    end
  end

  // Offers one beat for one cycle; called and returns just after a rising edge.
  task automatic try_push(input logic [W-1:0] d, output bit accepted);
    in_valid = 1'b1;
    wdata    = d;
    @(negedge clk);
    accepted = in_ready;
    if (accepted) sb_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wdata    = 'x;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, W'(sb_q.size()), '0);
  endtask

  bit acc;
  logic [W-1:0] stream_vals[3];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wdata     = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_rdata", rdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, 1-cycle latency
    out_ready = 1'b1;
    try_push(32'hA5A5_1234, acc);
    check("single_accepted", W'(acc), W'(1));
    check("single_out_valid", W'(out_valid), W'(1));
    check("single_rdata", rdata, 32'hA5A5_1234);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_drained_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;

    // Stall: held beat must stay stable
    out_ready = 1'b0;
    try_push(32'hDEAD_BEEF, acc);
    check("stall_accepted", W'(acc), W'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_rdata", rdata, 32'hDEAD_BEEF);
      check("stall_in_ready", W'(in_ready), W'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_drained_valid", W'(out_valid), W'(0));
    check("stall_sb_empty", W'(sb_q.size()), '0);
    @(posedge clk);
    #1;

    // Fill to FULL with 1,2; beat 3 must stall until the consumer frees a slot
    out_ready = 1'b0;
    stream_vals[0] = 32'd1;
    stream_vals[1] = 32'd2;
    stream_vals[2] = 32'd3;
    try_push(stream_vals[0], acc);
    check("full_beat1_acc", W'(acc), W'(1));
    try_push(stream_vals[1], acc);
    check("full_beat2_acc", W'(acc), W'(1));
    for (int i = 0; i < 3; i++) begin
      try_push(stream_vals[2], acc);
      check("full_beat3_stalled", W'(acc), W'(0));
    end
    check("full_rdata_head", rdata, 32'd1);
    out_ready = 1'b1;
    begin
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 10) begin
        try_push(stream_vals[2], acc);
        tries++;
      end
      check("full_beat3_eventually_acc", W'(acc), W'(1));
    end
    wait_drain("full_drain");

    // Continuous stream at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      try_push(W'(i), acc);
      check("stream_in_ready", W'(acc), W'(1));
    end
    wait_drain("stream_drain");

    // Reset while FULL discards both held beats
    out_ready = 1'b0;
    try_push(32'h0000_0011, acc);
    try_push(32'h0000_0022, acc);
    @(negedge clk);
    check("prereset_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_in_ready", W'(in_ready), W'(1));
    check("midreset_rdata", rdata, '0);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("postreset_no_stale", W'(out_valid), W'(0));
    end

    check("final_sb_empty", W'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
